// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU run/stop/step controller: state encoding and
// default timing parameters.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_STOP = 3'd1,
    ST_RUN  = 3'd2,
    ST_STEP = 3'd3
  } state_e;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 16;
  localparam int DEFAULT_INIT_CYCLES     = 4;

endpackage

// File: rtl/cpu_run_controller_button_conditioner.sv
// Push-button conditioner: 2-FF synchroniser, counting debouncer and a
// registered one-cycle pulse on the debounced rising edge.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q;

  // Any sample that agrees with the current level restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) level_d = ~level_q;
      else                                   cnt_d   = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      pulse_q <= level_d & ~level_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/cpu_run_controller.sv
// Run/stop/step sequencer for the CPU core: conditions the board buttons and
// drives CPU enable/start. CPU_RUN_CYCLE_COUNT_EN enables the run_cycles counter.
module cpu_run_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int PC_WIDTH        = 32,
  parameter int STEP_WIDTH      = 8,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int INIT_CYCLES     = DEFAULT_INIT_CYCLES
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  btn_start,
  input  logic                  btn_stop,
  input  logic                  btn_inc,
  input  logic [STEP_WIDTH-1:0] step_count,
  input  logic [PC_WIDTH-1:0]   pc,
  input  logic [PC_WIDTH-1:0]   bp_addr,
  input  logic                  bp_valid,
  output logic                  enable_control,
  output logic                  start_control,
  output logic [2:0]            state_out,
  output logic                  bp_hit,
  output logic [31:0]           run_cycles
);

  localparam int NUM_BTN = 3;
  localparam int IW      = $clog2(INIT_CYCLES + 1);

  logic [NUM_BTN-1:0] btn_raw, btn_pulse;
  logic               start_pulse, stop_pulse, inc_pulse;

  assign btn_raw = {btn_inc, btn_stop, btn_start};

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
      .clk_i  (clock),
      .rst_ni (reset),
      .btn_i  (btn_raw[g]),
      .pulse_o(btn_pulse[g])
    );
  end

  assign start_pulse = btn_pulse[0];
  assign stop_pulse  = btn_pulse[1];
  assign inc_pulse   = btn_pulse[2];

  state_e                state_q;
  logic [IW-1:0]         init_cnt_q;
  logic [STEP_WIDTH-1:0] step_cnt_q;
  logic                  armed_q;
  logic                  bp_hit_q;
  logic                  en_q;
  logic                  start_q;

  logic                  bp_match;
  logic [STEP_WIDTH-1:0] step_load;

  // armed_q masks the first cycle after leaving STOP so a resume from the
  // breakpoint address does not halt again straight away.
  assign bp_match  = bp_valid && (pc == bp_addr) && armed_q;
  assign step_load = (step_count == '0) ? STEP_WIDTH'(1) : step_count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      step_cnt_q <= '0;
      armed_q    <= 1'b0;
      bp_hit_q   <= 1'b0;
      en_q       <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          if (init_cnt_q == IW'(INIT_CYCLES - 1)) begin
            state_q <= ST_STOP;
            start_q <= 1'b1;
          end else begin
            init_cnt_q <= init_cnt_q + IW'(1);
          end
        end
        ST_STOP: begin
          start_q <= 1'b1;
          if (start_pulse) begin
            state_q  <= ST_RUN;
            en_q     <= 1'b1;
            armed_q  <= 1'b0;
            bp_hit_q <= 1'b0;
          end else if (inc_pulse) begin
            state_q    <= ST_STEP;
            en_q       <= 1'b1;
            step_cnt_q <= step_load;
            armed_q    <= 1'b0;
            bp_hit_q   <= 1'b0;
          end
        end
        ST_RUN: begin
          armed_q <= 1'b1;
          if (stop_pulse || bp_match) begin
            state_q  <= ST_STOP;
            en_q     <= 1'b0;
            bp_hit_q <= bp_match;
          end
        end
        ST_STEP: begin
          armed_q    <= 1'b1;
          step_cnt_q <= step_cnt_q - STEP_WIDTH'(1);
          if (stop_pulse || bp_match || step_cnt_q == STEP_WIDTH'(1)) begin
            state_q  <= ST_STOP;
            en_q     <= 1'b0;
            bp_hit_q <= bp_match;
          end
        end
        default: begin
          state_q <= ST_STOP;
          en_q    <= 1'b0;
          start_q <= 1'b1;
        end
      endcase
    end
  end

  assign enable_control = en_q;
  assign start_control  = start_q;
  assign state_out      = state_q;
  assign bp_hit         = bp_hit_q;

`ifdef CPU_RUN_CYCLE_COUNT_EN
  logic [31:0] run_cnt_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)    run_cnt_q <= '0;
    else if (en_q) run_cnt_q <= run_cnt_q + 32'd1;
  end

  assign run_cycles = run_cnt_q;
`else
  assign run_cycles = '0;
`endif

endmodule

// File: tb/tb_cpu_run_controller.sv
// Scoreboard bench for cpu_run_controller: each run/step episode's expected
// length and halt cause are queued by the stimulus and checked by a monitor.
module tb_cpu_run_controller;

  localparam int D   = 16;
  localparam int LAT = D + 3;  // press to first enabled cycle

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        btn_start = 1'b0, btn_stop = 1'b0, btn_inc = 1'b0;
  logic [7:0]  step_count = '0;
  logic [31:0] pc, bp_addr = '0;
  logic        bp_valid = 1'b0;
  logic        enable_control, start_control, bp_hit;
  logic [2:0]  state_out;
  logic [31:0] run_cycles;

  logic [31:0] cpu_pc = 32'h0000_1000;
  logic [31:0] man_pc = '0;
  logic        man_en = 1'b0;
  logic        cpu_last_en = 1'b0;

  assign pc = man_en ? man_pc : cpu_pc;

  cpu_run_controller #(
    .PC_WIDTH(32), .STEP_WIDTH(8), .DEBOUNCE_CYCLES(D), .INIT_CYCLES(4)
  ) dut (
    .clock(clock), .reset(reset),
    .btn_start(btn_start), .btn_stop(btn_stop), .btn_inc(btn_inc),
    .step_count(step_count), .pc(pc), .bp_addr(bp_addr), .bp_valid(bp_valid),
    .enable_control(enable_control), .start_control(start_control),
    .state_out(state_out), .bp_hit(bp_hit), .run_cycles(run_cycles)
  );

  always #5 clock = ~clock;

  typedef struct {
    int len;
    bit bp;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0, n_fail = 0;
  int   en_total = 0, mon_len = 0;
  bit   mon_prev = 1'b0;
  exp_t mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Toy CPU: one instruction commits per enabled cycle, pc advances by 4.
  initial forever begin
    @(negedge clock);
    if (cpu_last_en) cpu_pc = cpu_pc + 32'd4;
    cpu_last_en = enable_control;
  end

  // Monitor: an episode is a maximal run of enabled cycles outside reset.
  initial forever begin
    @(negedge clock);
    if (!reset) begin
      mon_len  = 0;
      mon_prev = 1'b0;
      en_total = 0;
    end else begin
      if (enable_control) begin
        if (!mon_prev) check("bp_hit_clear_on_leave_stop", {31'd0, bp_hit}, 32'd0);
        mon_len++;
        en_total++;
      end else if (mon_prev) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_episode: got len %0d expected no episode", mon_len);
        end else begin
          mon_e = exp_q.pop_front();
          check("episode_len", mon_len, mon_e.len);
          check("episode_bp_hit", {31'd0, bp_hit}, {31'd0, mon_e.bp});
          check("episode_end_state", {29'd0, state_out}, 32'd1);
        end
        mon_len = 0;
      end
      mon_prev = enable_control;
    end
  end

  task automatic wait_episode(input string name);
    int n;
    bit seen;
    n    = 0;
    seen = enable_control;
    while (!(seen && !enable_control) && n < 400) begin
      @(negedge clock);
      n++;
      if (enable_control) seen = 1'b1;
    end
    if (n >= 400) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got no completed episode expected one within 400 cycles", name);
    end
  endtask

  task automatic wait_rise(input string name, output int n);
    n = 0;
    while (!enable_control && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!enable_control) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got enable 0 expected 1 within 200 cycles", name);
    end
  endtask

  task automatic settle();
    btn_start = 1'b0;
    btn_stop  = 1'b0;
    btn_inc   = 1'b0;
    repeat (D + 8) @(negedge clock);
  endtask

  task automatic run_stop(input int glitches, input int r);
    repeat (glitches) begin
      btn_start = 1'b1; repeat (2) @(negedge clock);
      btn_start = 1'b0; repeat (2) @(negedge clock);
    end
    btn_start = 1'b1;
    exp_q.push_back('{r, 1'b0});
    repeat (r) @(negedge clock);
    btn_stop = 1'b1;
    wait_episode("run_stop");
    repeat (20) @(negedge clock);
    settle();
  endtask

  task automatic do_step(input int n);
    step_count = n[7:0];
    exp_q.push_back('{(n == 0) ? 1 : n, 1'b0});
    btn_inc = 1'b1;
    wait_episode("step");
    settle();
  endtask

  task automatic run_bp(input int k, input bit use_step, input int n);
    bp_valid   = 1'b1;
    bp_addr    = cpu_pc + 32'(4 * (k - 1));
    step_count = n[7:0];
    exp_q.push_back('{k, 1'b1});
    if (use_step) btn_inc = 1'b1;
    else          btn_start = 1'b1;
    wait_episode("breakpoint");
    bp_valid = 1'b0;
    settle();
  endtask

  int n_lat, kk, nn;

  initial begin
    // Reset state and INIT hold-off.
    repeat (3) @(negedge clock);
    check("reset_enable", {31'd0, enable_control}, 32'd0);
    check("reset_start", {31'd0, start_control}, 32'd0);
    check("reset_state", {29'd0, state_out}, 32'd0);
    check("reset_bp_hit", {31'd0, bp_hit}, 32'd0);
    check("reset_run_cycles", run_cycles, 32'd0);
    reset = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clock);
      check("init_start_low", {31'd0, start_control}, 32'd0);
    end
    @(negedge clock);
    check("init_start_high", {31'd0, start_control}, 32'd1);
    check("init_to_stop", {29'd0, state_out}, 32'd1);
    check("init_enable_low", {31'd0, enable_control}, 32'd0);
    repeat (4) @(negedge clock);

    // Start latency, then stop pressed in the first enabled cycle.
    btn_start = 1'b1;
    exp_q.push_back('{LAT, 1'b0});
    wait_rise("start_latency", n_lat);
    check("start_latency", n_lat, LAT);
    btn_stop = 1'b1;
    wait_episode("latency_stop");
    repeat (20) @(negedge clock);
    settle();

    run_stop(3, 10);
    do_step(3);
    do_step(0);

    // Halt at 0x40, then resume with pc still at 0x40.
    man_en = 1'b1; man_pc = 32'h3C; bp_addr = 32'h40; bp_valid = 1'b1;
    btn_start = 1'b1;
    exp_q.push_back('{2, 1'b1});
    wait_rise("bp40_run", n_lat);
    man_pc = 32'h40;
    wait_episode("bp40_halt");
    settle();
    btn_start = 1'b1;
    exp_q.push_back('{LAT, 1'b0});
    wait_rise("bp40_resume", n_lat);
    man_pc   = 32'h44;
    btn_stop = 1'b1;
    wait_episode("bp40_resume");
    settle();
    man_en = 1'b0; bp_valid = 1'b0;

    // start and inc pulse together: RUN wins over a 2-instruction step.
    step_count = 8'd2;
    btn_start  = 1'b1;
    btn_inc    = 1'b1;
    exp_q.push_back('{7, 1'b0});
    repeat (7) @(negedge clock);
    btn_stop = 1'b1;
    wait_episode("start_inc");
    settle();

    // stop pulse lands in the same cycle as the breakpoint match.
    bp_valid  = 1'b1;
    bp_addr   = cpu_pc + 32'(4 * 9);
    btn_start = 1'b1;
    exp_q.push_back('{10, 1'b1});
    repeat (10) @(negedge clock);
    btn_stop = 1'b1;
    wait_episode("stop_and_bp");
    bp_valid = 1'b0;
    settle();

    for (int i = 0; i < 10; i++) begin
      case ($urandom_range(0, 3))
        0: run_stop($urandom_range(0, 2), $urandom_range(3, 20));
        1: do_step($urandom_range(0, 6));
        2: run_bp($urandom_range(2, 15), 1'b0, 0);
        default: begin
          nn = $urandom_range(6, 15);
          kk = $urandom_range(2, nn - 1);
          run_bp(kk, 1'b1, nn);
        end
      endcase
    end

    check("scoreboard_drained", exp_q.size(), 32'd0);
`ifdef CPU_RUN_CYCLE_COUNT_EN
    check("run_cycles_total", run_cycles, en_total);
`else
    check("run_cycles_tied", run_cycles, 32'd0);
`endif

    // Reset asserted mid-STEP with the step counter at 5.
    step_count = 8'd10;
    btn_inc    = 1'b1;
    wait_rise("midstep", n_lat);
    repeat (5) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("midstep_enable", {31'd0, enable_control}, 32'd0);
    check("midstep_start", {31'd0, start_control}, 32'd0);
    check("midstep_state", {29'd0, state_out}, 32'd0);
    check("midstep_run_cycles", run_cycles, 32'd0);
    btn_inc = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (D + 8) @(negedge clock);
    check("midstep_recover_state", {29'd0, state_out}, 32'd1);
    check("midstep_recover_enable", {31'd0, enable_control}, 32'd0);
    check("midstep_no_episode", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test expected finish before 2ms");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
